// File: rtl/cpu_params_pkg.sv
// Purpose: shared pipeline sizing defaults for the RV32IM core.
// Latency: n/a (constants only).
// Backpressure: n/a.
package cpu_params_pkg;

  // Pending-result FIFO entries in write-back (power of 2, >= 2).
  localparam int WB_DEPTH_DEFAULT = 2;

  // Width of the retired-instruction counter behind CSR instret.
  localparam int INSTRET_W_DEFAULT = 64;

endpackage

// File: rtl/cpu_structs_pkg.sv
// Purpose: inter-stage payload types for the RV32IM pipeline.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package cpu_structs_pkg;

  // Memory -> Write-back result.
  typedef struct packed {
    logic        Rd_wr;
    logic [4:0]  Rd_addr;
    logic [31:0] Rd_data;
  } MEM_2_WB;

  // True when a result really updates the GPR file; x0 is hard-wired to zero,
  // so a write aimed at it is architecturally a no-op.
  function automatic logic gpr_writes(input MEM_2_WB e);
    return e.Rd_wr && (e.Rd_addr != 5'd0);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Purpose: pending write-back result queue with a youngest-first GPR match vector.
// Latency: push visible to match/head on the cycle after the accepting edge.
// Backpressure: caller must not push when full; push/pop are also gated internally.
//
// Ports:
//   clk_in, reset_in      clock, async active-high reset
//   push_vld / push_dat   enqueue request and payload
//   pop                   dequeue the head entry
//   head_dat              oldest entry
//   full, empty           occupancy flags
//   match_addr            GPR address to look up
//   match_vec / match_dat per-entry hit and data, index 0 = youngest entry
module wb_fifo
  import cpu_structs_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk_in,
  input  logic                   reset_in,
  input  logic                   push_vld,
  input  MEM_2_WB                push_dat,
  input  logic                   pop,
  output MEM_2_WB                head_dat,
  output logic                   full,
  output logic                   empty,
  input  logic [4:0]             match_addr,
  output logic [DEPTH-1:0]       match_vec,
  output logic [DEPTH-1:0][31:0] match_dat
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  MEM_2_WB            mem_q [DEPTH];
  MEM_2_WB            mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]   count_q, count_d;
  logic               push_ok;
  logic               pop_ok;

  assign full     = (count_q == OCC_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign head_dat = mem_q[rd_ptr_q];

  always_comb begin
    push_ok  = push_vld && !full;
    pop_ok   = pop && !empty;
    mem_d    = mem_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_dat;
    end
    // Pointers are exactly log2(DEPTH) bits, so they wrap for free.
    wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
    count_d  = count_q + OCC_W'(push_ok) - OCC_W'(pop_ok);
  end

  // Walk back from the write pointer so slot 0 is always the newest entry;
  // only the first count_q slots hold live results.
  always_comb begin
    logic [PTR_W-1:0] slot;
    slot      = '0;
    match_vec = '0;
    match_dat = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot         = wr_ptr_q - PTR_W'(i + 1);
      match_vec[i] = (OCC_W'(i) < count_q) && gpr_writes(mem_q[slot]) &&
                     (mem_q[slot].Rd_addr == match_addr);
      match_dat[i] = mem_q[slot].Rd_data;
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/wb_stage.sv
// Purpose: RV32IM write-back stage: queue MEM results, retire one per cycle to the GPRs.
// Latency: accept at edge t into an empty queue -> GPR write strobe during t+1..t+2.
// Backpressure: m2w_rdy drops when full, halted or in reset; wb_stall_in freezes retirement.
//
// Ports:
//   clk_in, reset_in           clock, async active-high reset
//   cpu_halt                   stop accepting, keep draining
//   m2w_valid/m2w_rdy/m2w_data Memory-stage result handshake
//   wb_stall_in                GPR port borrowed elsewhere; hold retirement
//   gpr_wr/gpr_addr/gpr_data   registered GPR write port
//   fwd_addr_in/fwd_hit/fwd_data  youngest-first forwarding of pending writes
//   instret                    retired-instruction count
module wb_stage
  import cpu_params_pkg::*;
  import cpu_structs_pkg::*;
#(
  parameter int WB_DEPTH = WB_DEPTH_DEFAULT,
  parameter int CNT_W    = INSTRET_W_DEFAULT
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             cpu_halt,
  input  logic             m2w_valid,
  output logic             m2w_rdy,
  input  MEM_2_WB          m2w_data,
  input  logic             wb_stall_in,
  output logic             gpr_wr,
  output logic [4:0]       gpr_addr,
  output logic [31:0]      gpr_data,
  input  logic [4:0]       fwd_addr_in,
  output logic             fwd_hit,
  output logic [31:0]      fwd_data,
  output logic [CNT_W-1:0] instret
);

  MEM_2_WB                   head_dat;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [WB_DEPTH-1:0]       match_vec;
  logic [WB_DEPTH-1:0][31:0] match_dat;
  logic                      push_vld;
  logic                      pop;

  logic                      gpr_wr_q, gpr_wr_d;
  logic [4:0]                gpr_addr_q, gpr_addr_d;
  logic [31:0]               gpr_data_q, gpr_data_d;
  logic [CNT_W-1:0]          instret_q, instret_d;

  wb_fifo #(
    .DEPTH (WB_DEPTH)
  ) u_fifo (
    .clk_in     (clk_in),
    .reset_in   (reset_in),
    .push_vld   (push_vld),
    .push_dat   (m2w_data),
    .pop        (pop),
    .head_dat   (head_dat),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .match_addr (fwd_addr_in),
    .match_vec  (match_vec),
    .match_dat  (match_dat)
  );

  // No full-bypass: a full queue refuses even when it retires this cycle,
  // which keeps rdy off the retire/stall timing path.
  always_comb begin
    m2w_rdy  = !reset_in && !cpu_halt && !fifo_full;
    push_vld = m2w_valid && m2w_rdy;
    pop      = !fifo_empty && !wb_stall_in;
  end

  // Retire register: x0 targets still retire (and count) but never strobe.
  always_comb begin
    gpr_wr_d   = 1'b0;
    gpr_addr_d = gpr_addr_q;
    gpr_data_d = gpr_data_q;
    if (pop) begin
      gpr_wr_d   = gpr_writes(head_dat);
      gpr_addr_d = head_dat.Rd_addr;
      gpr_data_d = head_dat.Rd_data;
    end
    instret_d = instret_q + CNT_W'(pop);
  end

  // Oldest source first, younger sources overwrite: the retire register,
  // then queue slots from oldest (highest index) to youngest (index 0).
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (gpr_wr_q && (gpr_addr_q == fwd_addr_in)) begin
      fwd_hit  = 1'b1;
      fwd_data = gpr_data_q;
    end
    for (int i = WB_DEPTH - 1; i >= 0; i--) begin
      if (match_vec[i]) begin
        fwd_hit  = 1'b1;
        fwd_data = match_dat[i];
      end
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      gpr_wr_q   <= 1'b0;
      gpr_addr_q <= '0;
      gpr_data_q <= '0;
      instret_q  <= '0;
    end else begin
      gpr_wr_q   <= gpr_wr_d;
      gpr_addr_q <= gpr_addr_d;
      gpr_data_q <= gpr_data_d;
      instret_q  <= instret_d;
    end
  end

  assign gpr_wr   = gpr_wr_q;
  assign gpr_addr = gpr_addr_q;
  assign gpr_data = gpr_data_q;
  assign instret  = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Purpose: directed self-checking bench for wb_stage with a GPR-write scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_wb_stage;
  import cpu_structs_pkg::*;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic        cpu_halt;
  logic        m2w_valid;
  logic        m2w_rdy;
  MEM_2_WB     m2w_data;
  logic        wb_stall_in;
  logic        gpr_wr;
  logic [4:0]  gpr_addr;
  logic [31:0] gpr_data;
  logic [4:0]  fwd_addr_in;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic [63:0] instret;

  int checks = 0;
  int errors = 0;

  MEM_2_WB exp_q[$];
  MEM_2_WB mon_e;
  logic [63:0] all_ones;

  always #5 clk_in = ~clk_in;

  wb_stage #(
    .WB_DEPTH (2),
    .CNT_W    (64)
  ) dut (
    .clk_in      (clk_in),
    .reset_in    (reset_in),
    .cpu_halt    (cpu_halt),
    .m2w_valid   (m2w_valid),
    .m2w_rdy     (m2w_rdy),
    .m2w_data    (m2w_data),
    .wb_stall_in (wb_stall_in),
    .gpr_wr      (gpr_wr),
    .gpr_addr    (gpr_addr),
    .gpr_data    (gpr_data),
    .fwd_addr_in (fwd_addr_in),
    .fwd_hit     (fwd_hit),
    .fwd_data    (fwd_data),
    .instret     (instret)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Present a result; if it really writes a GPR, the scoreboard expects it.
  task automatic offer(input logic wr, input logic [4:0] addr, input logic [31:0] data);
    MEM_2_WB e;
    e.Rd_wr   = wr;
    e.Rd_addr = addr;
    e.Rd_data = data;
    m2w_data  = e;
    m2w_valid = 1'b1;
    if (wr && addr != 5'd0) exp_q.push_back(e);
  endtask

  // Write-port monitor and invariants, sampled on the falling edge.
  always @(negedge clk_in) begin
    if (!reset_in) begin
      chk("inv_no_x0_write", 64'(gpr_wr && gpr_addr == 5'd0), 64'd0);
      if (m2w_rdy) chk("inv_rdy_guard", 64'(cpu_halt || dut.u_fifo.count_q == 2'd2), 64'd0);
      if (gpr_wr) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_write", 64'(gpr_addr), 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("sb_addr", 64'(gpr_addr), 64'(mon_e.Rd_addr));
          chk("sb_data", 64'(gpr_data), 64'(mon_e.Rd_data));
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    all_ones    = '1;
    reset_in    = 1'b0;
    cpu_halt    = 1'b0;
    m2w_valid   = 1'b0;
    m2w_data    = '0;
    wb_stall_in = 1'b0;
    fwd_addr_in = 5'd0;
    #1 reset_in = 1'b1;
    #1;
    chk("rst_rdy",     64'(m2w_rdy), 64'd0);
    chk("rst_gpr_wr",  64'(gpr_wr),  64'd0);
    chk("rst_gpr_addr",64'(gpr_addr),64'd0);
    chk("rst_gpr_data",64'(gpr_data),64'd0);
    chk("rst_instret", instret,      64'd0);
    chk("rst_fwd_hit", 64'(fwd_hit), 64'd0);
    step();
    step();
    reset_in = 1'b0;
    #1;
    chk("post_rst_rdy", 64'(m2w_rdy), 64'd1);

    // Back-to-back pushes, one retire per cycle.
    offer(1'b1, 5'd5, 32'h11);
    chk("t2_rdy_a", 64'(m2w_rdy), 64'd1);
    step();
    offer(1'b1, 5'd6, 32'h22);
    chk("t2_rdy_b", 64'(m2w_rdy), 64'd1);
    step();
    chk("t2_wr_a", 64'(gpr_wr), 64'd1);
    offer(1'b1, 5'd7, 32'h33);
    chk("t2_rdy_c", 64'(m2w_rdy), 64'd1);
    step();
    chk("t2_wr_b", 64'(gpr_wr), 64'd1);
    m2w_valid = 1'b0;
    step();
    chk("t2_wr_c", 64'(gpr_wr), 64'd1);
    chk("t2_instret", instret, 64'd3);
    step();
    chk("t2_wr_idle", 64'(gpr_wr), 64'd0);

    // Stall: fill queue, youngest-first forwarding, refused offer.
    wb_stall_in = 1'b1;
    offer(1'b1, 5'd8, 32'hA);
    step();
    chk("t3_rdy_one", 64'(m2w_rdy), 64'd1);
    offer(1'b1, 5'd8, 32'hB);
    step();
    m2w_valid   = 1'b0;
    fwd_addr_in = 5'd8;
    #1;
    chk("t3_rdy_full", 64'(m2w_rdy), 64'd0);
    chk("t3_fwd_hit",  64'(fwd_hit), 64'd1);
    chk("t3_fwd_data", 64'(fwd_data), 64'hB);
    m2w_data  = '{Rd_wr: 1'b1, Rd_addr: 5'd9, Rd_data: 32'h99};
    m2w_valid = 1'b1;
    step();
    m2w_valid = 1'b0;
    chk("t3_no_capture", 64'(dut.u_fifo.count_q), 64'd2);
    chk("t3_instret_frozen", instret, 64'd3);
    fwd_addr_in = 5'd9;
    #1;
    chk("t3_fwd_miss_hit",  64'(fwd_hit), 64'd0);
    chk("t3_fwd_miss_data", 64'(fwd_data), 64'd0);
    fwd_addr_in = 5'd8;
    wb_stall_in = 1'b0;
    step();
    chk("t3_fwd_after_pop1", 64'(fwd_data), 64'hB);
    step();
    chk("t3_fwd_retire_hit",  64'(fwd_hit), 64'd1);
    chk("t3_fwd_retire_data", 64'(fwd_data), 64'hB);
    step();
    chk("t3_fwd_gone", 64'(fwd_hit), 64'd0);
    chk("t3_instret", instret, 64'd5);

    // Write to x0: retires and counts, no strobe, no forward.
    offer(1'b1, 5'd0, 32'hDEAD);
    fwd_addr_in = 5'd0;
    step();
    m2w_valid = 1'b0;
    #1;
    chk("t4_fwd_x0", 64'(fwd_hit), 64'd0);
    step();
    chk("t4_gpr_wr", 64'(gpr_wr), 64'd0);
    chk("t4_instret", instret, 64'd6);

    // Halt with two queued: refuse, drain, resume.
    wb_stall_in = 1'b1;
    offer(1'b1, 5'd10, 32'h10A);
    step();
    offer(1'b1, 5'd11, 32'h10B);
    step();
    cpu_halt    = 1'b1;
    wb_stall_in = 1'b0;
    m2w_data    = '{Rd_wr: 1'b1, Rd_addr: 5'd12, Rd_data: 32'h10C};
    fwd_addr_in = 5'd11;
    #1;
    chk("t5_rdy_halt0", 64'(m2w_rdy), 64'd0);
    chk("t5_fwd_data",  64'(fwd_data), 64'h10B);
    step();
    chk("t5_rdy_halt1", 64'(m2w_rdy), 64'd0);
    step();
    chk("t5_rdy_halt2", 64'(m2w_rdy), 64'd0);
    chk("t5_drained", 64'(dut.u_fifo.count_q), 64'd0);
    chk("t5_instret", instret, 64'd8);
    cpu_halt  = 1'b0;
    m2w_valid = 1'b0;
    #1;
    chk("t5_rdy_resume", 64'(m2w_rdy), 64'd1);
    step();

    // instret wrap from all-ones.
    wb_stall_in = 1'b1;
    force dut.instret_q = all_ones;
    step();
    release dut.instret_q;
    #1;
    chk("t6_preload", instret, all_ones);
    offer(1'b1, 5'd13, 32'h13);
    step();
    offer(1'b0, 5'd14, 32'h14);
    step();
    m2w_valid   = 1'b0;
    wb_stall_in = 1'b0;
    step();
    chk("t6_wrap0", instret, 64'd0);
    step();
    chk("t6_wrap1", instret, 64'd1);
    step();

    // Reset mid-stream with two entries queued.
    wb_stall_in = 1'b1;
    offer(1'b1, 5'd15, 32'h15);
    step();
    offer(1'b1, 5'd16, 32'h16);
    step();
    m2w_valid = 1'b0;
    chk("t1_queued", 64'(dut.u_fifo.count_q), 64'd2);
    reset_in    = 1'b1;
    fwd_addr_in = 5'd15;
    #1;
    exp_q.delete();
    chk("t1_count",   64'(dut.u_fifo.count_q), 64'd0);
    chk("t1_gpr_wr",  64'(gpr_wr), 64'd0);
    chk("t1_instret", instret, 64'd0);
    chk("t1_rdy",     64'(m2w_rdy), 64'd0);
    chk("t1_fwd",     64'(fwd_hit), 64'd0);
    wb_stall_in = 1'b0;
    step();
    chk("t1_rdy_held", 64'(m2w_rdy), 64'd0);
    reset_in = 1'b0;
    #1;
    chk("t1_rdy_release", 64'(m2w_rdy), 64'd1);
    step();
    step();
    step();
    chk("t1_instret_idle", instret, 64'd0);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
